// File: rtl/dpll_pkg.sv
//------------------------------------------------------------------------------
// Module   : dpll_pkg
// Brief    : Shared types and helpers for the DPLL gear-shifting loop filter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dpll_pkg;

    typedef enum logic {
        GEAR_ACQ = 1'b0,
        GEAR_TRK = 1'b1
    } gear_e;

    // Clamp a signed value into the unsigned range [0, 2^width-1]
    function automatic logic signed [63:0] sat_u(input logic signed [63:0] value,
                                                 input int                 width);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< width) - 64'sd1;
        if (value < 0) begin
            return '0;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

    // Operates on a sign-extended copy, so the most negative TDC code cannot overflow
    function automatic logic signed [31:0] abs_s(input logic signed [31:0] terr);
        return (terr < 0) ? -terr : terr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpll_lock_det.sv
//------------------------------------------------------------------------------
// Module   : dpll_lock_det
// Brief    : Lock window compare, qualification counters and ACQ/TRK gear FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dpll_lock_det
    import dpll_pkg::*;
#(
    parameter int TERR_W     = 4,
    parameter int LOCK_WIN   = 1,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ACQ_MIN    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [TERR_W-1:0] terr,
    output gear_e                    gear,
    output logic                     locked
);

    gear_e       state_q, state_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic [31:0] acq_cnt_q, acq_cnt_d;
    logic        w_in_win;

    always_comb begin
        w_in_win  = (abs_s(32'(terr)) <= LOCK_WIN);
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        acq_cnt_d = acq_cnt_q;
        if (en) begin
            case (state_q)
                GEAR_ACQ: begin
                    acq_cnt_d = (acq_cnt_q >= ACQ_MIN) ? acq_cnt_q : acq_cnt_q + 32'd1;
                    if (w_in_win) begin
                        in_cnt_d = (in_cnt_q >= LOCK_CNT) ? in_cnt_q : in_cnt_q + 32'd1;
                    end else begin
                        in_cnt_d = '0;
                    end
                    // Qualify on the updated counts so the lock lands on the completing edge
                    if ((in_cnt_d >= LOCK_CNT) && (acq_cnt_d >= ACQ_MIN)) begin
                        state_d   = GEAR_TRK;
                        in_cnt_d  = '0;
                        acq_cnt_d = '0;
                        out_cnt_d = '0;
                    end
                end
                GEAR_TRK: begin
                    if (w_in_win) begin
                        out_cnt_d = '0;
                    end else begin
                        out_cnt_d = (out_cnt_q >= UNLOCK_CNT) ? out_cnt_q : out_cnt_q + 32'd1;
                    end
                    if (out_cnt_d >= UNLOCK_CNT) begin
                        state_d   = GEAR_ACQ;
                        in_cnt_d  = '0;
                        acq_cnt_d = '0;
                        out_cnt_d = '0;
                    end
                end
                default: state_d = GEAR_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= GEAR_ACQ;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            acq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            acq_cnt_q <= acq_cnt_d;
        end
    end

    assign gear   = state_q;
    assign locked = (state_q == GEAR_TRK);

endmodule

`default_nettype wire

// File: rtl/dpll_lf_gear.sv
//------------------------------------------------------------------------------
// Module   : dpll_lf_gear
// Brief    : Two-gear PI loop filter with bang-bang option, lock detect and clamp.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dpll_lf_gear
    import dpll_pkg::*;
#(
    parameter int TERR_W     = 4,
    parameter int DCTRL_W    = 13,
    parameter int INIT_VALUE = 1 << (DCTRL_W - 1),
    parameter int KP_SH_ACQ  = 6,
    parameter int KI_SH_ACQ  = 1,
    parameter int KP_SH_TRK  = 5,
    parameter int KI_SH_TRK  = 0,
    parameter int LOCK_WIN   = 1,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ACQ_MIN    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [TERR_W-1:0] terr,
    input  logic                     en,
    input  logic                     mode_bb,
    output logic [DCTRL_W-1:0]       dctrl,
    output logic                     gear,
    output logic                     locked,
    output logic                     sat
);

    localparam int IW = DCTRL_W + TERR_W + 8;

    gear_e                     w_gear;
    logic signed [TERR_W-1:0]  w_err;
    int                        w_kp_sh;
    int                        w_ki_sh;
    logic signed [63:0]        w_i_sum, w_i_clamp, w_p_sum, w_p_clamp;
    logic signed [IW-1:0]      integ_q, integ_d;
    logic [DCTRL_W-1:0]        dctrl_q, dctrl_d;
    logic                      sat_q, sat_d;

    dpll_lock_det #(
        .TERR_W     (TERR_W),
        .LOCK_WIN   (LOCK_WIN),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .ACQ_MIN    (ACQ_MIN)
    ) u_lock_det (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .terr   (terr),
        .gear   (w_gear),
        .locked (locked)
    );

    always_comb begin
        if (mode_bb) begin
            w_err = terr[TERR_W-1] ? '1 : ((terr != '0) ? TERR_W'(1) : '0);
        end else begin
            w_err = terr;
        end
        w_kp_sh = (w_gear == GEAR_TRK) ? KP_SH_TRK : KP_SH_ACQ;
        w_ki_sh = (w_gear == GEAR_TRK) ? KI_SH_TRK : KI_SH_ACQ;

        // Proportional term rides on the already-clamped integrator value
        w_i_sum   = 64'(integ_q) + (64'(w_err) <<< w_ki_sh);
        w_i_clamp = sat_u(w_i_sum, DCTRL_W);
        w_p_sum   = w_i_clamp + (64'(w_err) <<< w_kp_sh);
        w_p_clamp = sat_u(w_p_sum, DCTRL_W);

        integ_d = integ_q;
        dctrl_d = dctrl_q;
        sat_d   = sat_q;
        if (en) begin
            integ_d = IW'(w_i_clamp);
            dctrl_d = DCTRL_W'(w_p_clamp);
            sat_d   = (w_i_clamp != w_i_sum) || (w_p_clamp != w_p_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            integ_q <= IW'(INIT_VALUE);
            dctrl_q <= DCTRL_W'(INIT_VALUE);
            sat_q   <= 1'b0;
        end else begin
            integ_q <= integ_d;
            dctrl_q <= dctrl_d;
            sat_q   <= sat_d;
        end
    end

    assign dctrl = dctrl_q;
    assign sat   = sat_q;
    assign gear  = (w_gear == GEAR_TRK);

endmodule

`default_nettype wire

// File: tb/tb_dpll_lf_gear.sv
//------------------------------------------------------------------------------
// Module   : tb_dpll_lf_gear
// Brief    : Directed and random scoreboard bench for dpll_lf_gear (default params).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dpll_lf_gear;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              mode_bb;
    logic signed [3:0] terr;
    logic [12:0]       dctrl;
    logic              gear;
    logic              locked;
    logic              sat;

    dpll_lf_gear u_dut (
        .clk     (clk),
        .reset   (reset),
        .terr    (terr),
        .en      (en),
        .mode_bb (mode_bb),
        .dctrl   (dctrl),
        .gear    (gear),
        .locked  (locked),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dctrl;
        int sat;
        int gear;
        int locked;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_i, m_d, m_sat, m_st, m_in, m_out, m_acq;

    function automatic int clampu(input int v);
        return (v < 0) ? 0 : ((v > 8191) ? 8191 : v);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model(input bit r, input bit e_n, input bit mb, input int t);
        int e, ki, kp, is, ic, ps, pc, a;
        if (r) begin
            m_i = 4096; m_d = 4096; m_sat = 0;
            m_st = 0; m_in = 0; m_out = 0; m_acq = 0;
        end else if (e_n) begin
            e  = mb ? ((t > 0) ? 1 : ((t < 0) ? -1 : 0)) : t;
            ki = (m_st != 0) ? 1 : 2;
            kp = (m_st != 0) ? 32 : 64;
            is = m_i + e * ki;
            ic = clampu(is);
            ps = ic + e * kp;
            pc = clampu(ps);
            m_sat = ((ic != is) || (pc != ps)) ? 1 : 0;
            m_i = ic;
            m_d = pc;
            a = (t < 0) ? -t : t;
            if (m_st == 0) begin
                if (m_acq < 32) m_acq++;
                if (a <= 1) begin
                    if (m_in < 16) m_in++;
                end else begin
                    m_in = 0;
                end
                if (m_in == 16 && m_acq >= 32) begin
                    m_st = 1; m_in = 0; m_out = 0; m_acq = 0;
                end
            end else begin
                if (a > 1) begin
                    if (m_out < 4) m_out++;
                end else begin
                    m_out = 0;
                end
                if (m_out == 4) begin
                    m_st = 0; m_in = 0; m_out = 0; m_acq = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e_n, input bit mb, input int t);
        exp_t x;
        reset   = r;
        en      = e_n;
        mode_bb = mb;
        terr    = 4'(t);
        model(r, e_n, mb, t);
        x.dctrl = m_d; x.sat = m_sat; x.gear = m_st; x.locked = m_st;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("dctrl",  int'(dctrl),  x.dctrl);
        chk("sat",    int'(sat),    x.sat);
        chk("gear",   int'(gear),   x.gear);
        chk("locked", int'(locked), x.locked);
    endtask

    initial begin
        int saved;
        int t;

        // Reset state and idle acquisition: ACQ_MIN gates the lock, not LOCK_CNT
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_dctrl", int'(dctrl), 4096);
        for (int i = 0; i < 31; i++) step(0, 1, 0, 0);
        chk("gear_before_acq_min", int'(gear), 0);
        step(0, 1, 0, 0);
        chk("gear_at_acq_min", int'(gear), 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        // Single +1 impulse in acquisition gear
        step(1, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("impulse_dctrl", int'(dctrl), 4162);
        step(0, 1, 0, 0);
        chk("impulse_after", int'(dctrl), 4098);

        // Lock, survive a short excursion, then lose lock
        for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
        chk("locked_after_run", int'(locked), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 7);
        step(0, 1, 0, 0);
        chk("locked_after_short_excursion", int'(locked), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, -8);
        chk("locked_before_unlock_edge", int'(locked), 1);
        step(0, 1, 0, -8);
        chk("unlocked", int'(locked), 0);
        chk("gear_acq_after_unlock", int'(gear), 0);
        saved = m_i;
        step(0, 1, 0, 0);
        chk("bumpless_integrator", int'(dctrl), saved);

        // Bang-bang: +5 behaves like +1
        step(1, 1, 0, 0);
        step(0, 1, 1, 5);
        chk("bb_dctrl", int'(dctrl), 4162);
        step(0, 1, 1, -3);

        // Upper clamp then release
        step(1, 1, 0, 0);
        for (int i = 0; i < 320; i++) step(0, 1, 0, 7);
        chk("clamp_dctrl", int'(dctrl), 8191);
        chk("clamp_sat", int'(sat), 1);
        step(0, 1, 0, -1);
        chk("release_sat", int'(sat), 0);
        chk("release_dctrl", int'(dctrl), 8125);

        // Lock again, freeze, then reset while tracking (reset beats en=0)
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0);
        chk("relocked", int'(locked), 1);
        saved = m_d;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 7);
        chk("frozen_dctrl", int'(dctrl), saved);
        chk("frozen_locked", int'(locked), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 7);
        chk("frozen_samples_not_counted", int'(locked), 1);
        step(1, 0, 0, 7);
        chk("reset_trk_dctrl", int'(dctrl), 4096);
        chk("reset_trk_locked", int'(locked), 0);

        // Mixed random traffic, mostly in-window so both gears get exercised
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) t = int'($urandom_range(0, 15)) - 8;
            else                           t = int'($urandom_range(0, 2)) - 1;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0), t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dpll_lf_gear.md
# dpll_lf_gear

Parametrised digital loop-filter/controller for the DPLL, sitting between the TDC and the DCO and clocked by the feedback clock. Successor to the fixed-gain PI loop filter. Adds:
- parameterised error and control widths;
- two-gear gain scheduling, with a wide acquisition gear and a narrow tracking gear;
- optional bang-bang (sign-only) error mode;
- a lock detector, saturation reporting and a freeze input.

Replaces the loop filter instance inside the PLL top.

## Interface
Parameters:
- TERR_W, 4, width of signed TDC error input
- DCTRL_W, 13, width of unsigned DCO control word
- INIT_VALUE, 1<<(DCTRL_W-1), integrator and dctrl reset value
- KP_SH_ACQ, 6, proportional gain shift in acquisition (Kp=64)
- KI_SH_ACQ, 1, integral gain shift in acquisition (Ki=2)
- KP_SH_TRK, 5, proportional gain shift in tracking (Kp=32)
- KI_SH_TRK, 0, integral gain shift in tracking (Ki=1)
- LOCK_WIN, 1, in-window threshold: |terr| <= LOCK_WIN
- LOCK_CNT, 16, consecutive in-window samples needed to lock
- UNLOCK_CNT, 4, consecutive out-of-window samples needed to unlock
- ACQ_MIN, 32, minimum cycles spent in ACQ before locking is allowed

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, loop clock (feedback clock, bit domain)
- reset, in, 1, synchronous active-high reset
- terr, in, TERR_W signed, TDC phase error
- en, in, 1, 1 = update; 0 = freeze all state
- mode_bb, in, 1, 1 = bang-bang: error used is sign(terr) ∈ {-1,0,+1}
- dctrl, out, DCTRL_W, DCO control word
- gear, out, 1, 0 = ACQ, 1 = TRK
- locked, out, 1, lock indication
- sat, out, 1, dctrl clamped this update

## Operation
- Effective error e: terr if mode_bb=0, else sign(terr). Lock window always uses raw terr. |−2^(TERR_W−1)| is computed without overflow.
- Gains come from the current registered gear: (KP_SH, KI_SH) = ACQ or TRK set.
- Integrator I is signed, width DCTRL_W+TERR_W+8.
  - I_next = clamp(I + (e <<< KI_SH), 0, 2^DCTRL_W−1)
- Control word: dctrl_next = clamp(I_next + (e <<< KP_SH), 0, 2^DCTRL_W−1).
- sat_next = 1 if either clamp was active, else 0.
- Gear change does not touch I (bumpless). Only the gains change.
- FSM states are ACQ and TRK. Counters in_cnt, out_cnt and acq_cnt saturate at their targets.
- ACQ:
  - acq_cnt increments each enabled cycle.
  - in_cnt counts consecutive in-window samples; an out-of-window sample clears it.
  - When in_cnt reaches LOCK_CNT and acq_cnt ≥ ACQ_MIN: go to TRK, gear=1, locked=1, out_cnt=0.
- TRK:
  - out_cnt counts consecutive out-of-window samples; an in-window sample clears it.
  - When out_cnt reaches UNLOCK_CNT: go to ACQ, gear=0, locked=0, all counters cleared.
- en=0: I, dctrl, sat, FSM and counters all hold. Samples taken while frozen do not count.
- reset overrides en.

## Timing
- Reset (synchronous, at the clk edge with reset=1):
  - dctrl=INIT_VALUE, I=INIT_VALUE
  - gear=0, locked=0, sat=0
  - state ACQ, all counters 0
- Latency: terr sampled at edge n appears in dctrl, sat and the counters after edge n. One-cycle registered path, no combinational path from terr to outputs.
- Gear/locked change after the edge that completes the qualifying count. The new gains apply from the next sample.
- Lock edge: with an in-window run starting at cycle 0 after reset and ACQ_MIN ≤ LOCK_CNT, locked rises after edge LOCK_CNT−1. Otherwise it rises at the first edge with both conditions met.
- Reset asserted mid-operation in any state: outputs return to reset values on that edge.

## Structure
- Package dpll_pkg holds:
  - typedef enum logic {GEAR_ACQ, GEAR_TRK} gear_e
  - function sat_u(value, width)
  - function abs_s(terr)
- Sub-module dpll_lock_det holds the window compare, the three counters and the FSM. Output: gear.
- The top holds error mapping, gain mux, integrator, proportional sum and clamps.

## Test plan
- Reset then terr=0 for 40 cycles → dctrl stays 4096; gear rises at cycle 32 (ACQ_MIN), not at 16; sat=0 throughout.
- ACQ, linear mode, terr=+1 for 1 cycle → I=4098, dctrl=4162; the following cycle with terr=0 → dctrl=4098.
- After lock (TRK), terr=+7 for 3 cycles then 0 → stays locked. terr=−8 for 4 cycles → unlocks after edge 4, gear=0, I unchanged across the switch.
- mode_bb=1, terr=+5 → e=+1, dctrl step identical to terr=+1. Lock window still sees 5 (out of window).
- Drive terr=+7 until clamp → dctrl=8191 and sat=1, no wrap. Then terr=−1 → sat=0 and dctrl decreases.
- en=0 for 10 cycles with terr=+7 → dctrl, counters and gear frozen. Reset during TRK → next cycle dctrl=4096, locked=0.
